hamming_serial_encoder: RTL and testbench
=========================================

HAMMING_SERIAL_ENCODER -- requirements
Module: hamming_serial_encoder

Interface
REQ-001 Parameter M, default 3: number of Hamming parity bits; legal values 3 or 4 only; K = 2^M-1-M data bits, N = 2^M-1 code bits.
REQ-002 Parameter EXT_PARITY, default 0: 1 appends one overall even-parity bit (SECDED), giving a codeword length of N+1.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 s_valid  input  1  upstream data bit valid.
REQ-006 s_data  input  1  upstream data bit, first-in bit is highest-order message bit.
REQ-007 s_ready  output  1  block accepts s_data this cycle.
REQ-008 m_valid  output  1  m_data holds a code bit.
REQ-009 m_data  output  1  serial code bit.
REQ-010 m_first  output  1  m_data is bit 0 of a codeword.
REQ-011 m_last  output  1  m_data is final bit of a codeword.
REQ-012 m_ready  input  1  downstream consumes m_data this cycle.

Function
REQ-013 Transfer on either port occurs only when valid and ready are both high on a rising edge.
REQ-014 The single-bit output register is "free" when m_valid=0 or m_ready=1; the register loads only when free.
REQ-015 The FSM has states DATA, PARITY, EXT; reset state is DATA; EXT is unreachable when EXT_PARITY=0.
REQ-016 s_ready = free AND state==DATA; it is asserted low in PARITY and EXT.
REQ-017 DATA, free, s_valid=1: m_data<=s_data, m_valid<=1, remainder updated, bit counter incremented.
REQ-018 DATA, free, s_valid=0: m_valid<=0; no other state changes.
REQ-019 Remainder update per data bit d: fb = d XOR rem[M-1]; rem <= (rem<<1) XOR (fb ? G : 0).
REQ-020 G is x^3+x+1 (3'b011 taps) for M=3 and x^4+x+1 (4'b0011 taps) for M=4.
REQ-021 Accepting data bit K-1 moves the FSM to PARITY.
REQ-022 PARITY, free: m_data<=rem[M-1], rem<=rem<<1, m_valid<=1, counter incremented; after M bits, the FSM moves to EXT (EXT_PARITY=1) or DATA.
REQ-023 EXT, free: m_data<=XOR of all N previously emitted bits of the codeword, m_valid<=1; the FSM then moves to DATA.
REQ-024 On codeword completion, the counter, rem and the parity accumulator clear to 0 in the same cycle the last bit loads.
REQ-025 m_first is asserted with counter index 0 and m_last with index N-1 (or N when EXT_PARITY=1); both are registered alongside m_data.
REQ-026 Input-to-output latency is 1 cycle; a continuous s_valid/m_ready stream yields one codeword per N(+1) cycles with no bubbles beyond the parity slots.
REQ-027 Holding m_ready=0 freezes m_data/m_first/m_last and all internal state.
REQ-028 The counter width is ceil(log2(N+2)); the counter never exceeds the codeword length minus one.

Reset
REQ-029 Reset is asserted as: m_valid=0, m_data=0, m_first=0, m_last=0, rem=0, counter=0, accumulator=0, state=DATA; s_ready is low in the reset cycle.
REQ-030 Reset mid-codeword discards the partial codeword; the first accepted bit after reset is bit 0 of a new codeword.

Structure
REQ-031 Package hamming_pkg holds the FSM state enum, G constants per M, and K/N derivation functions.
REQ-032 Sub-module hamming_rem_lfsr (parameter M; ports clk, reset, clear, shift_in, shift_out, din, rem) holds the remainder register.
REQ-033 An elaboration-time check rejects M outside {3,4}.

Verification
REQ-034 M=3, EXT=0, data 1,0,0,0 streamed -> m_data 1000101, m_first on bit 0, m_last on bit 6.
REQ-035 M=3, EXT=1, data 1,0,0,0 -> 10001011 (8 bits), m_last on the eighth bit.
REQ-036 M=4, EXT=0, data 1 then ten 0s -> 11 data bits followed by parity 1001; all-zero data -> fifteen 0s.
REQ-037 Random m_ready backpressure across 1000 codewords -> output matches a reference encoder bit-exact; s_ready is never high in PARITY/EXT.
REQ-038 Reset asserted after data bit 2 of a codeword, then data 1,1,0,1 -> m_valid=0 during reset; next output is 1101 plus correct parity 001 (M=3), with m_first on the first 1.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared types and constants for the serial Hamming encoder: FSM states,
// generator taps per parity-bit count, and code-size helpers.
package hamming_pkg;

   // Encoder phase: streaming message bits, emitting Hamming parity, or
   // emitting the optional overall even-parity bit.
   typedef enum logic [1:0] {
      ST_DATA   = 2'd0,
      ST_PARITY = 2'd1,
      ST_EXT    = 2'd2
   } state_e;

   // Generator feedback taps (the implicit x^M term is dropped).
   localparam logic [2:0] G_M3 = 3'b011;   // x^3 + x + 1
   localparam logic [3:0] G_M4 = 4'b0011;  // x^4 + x + 1

   // Code bits for M parity bits.
   function automatic int calc_n(input int m);
      return (1 << m) - 1;
   endfunction

   // Message bits for M parity bits.
   function automatic int calc_k(input int m);
      return (1 << m) - 1 - m;
   endfunction

   // Taps for M, zero-extended to the widest supported generator.
   function automatic logic [3:0] gen_taps(input int m);
      return (m == 4) ? G_M4 : {1'b0, G_M3};
   endfunction

endpackage

// File: rtl/hamming_serial_encoder_if.sv
// Bit-serial stream bundle around the encoder: upstream message bits in,
// downstream code bits out with codeword framing flags.
interface hamming_serial_encoder_if;

   logic s_valid;
   logic s_data;
   logic s_ready;
   logic m_valid;
   logic m_data;
   logic m_first;
   logic m_last;
   logic m_ready;

   // slave: the encoder's view. master: the surrounding system's view.
   modport slave (
      input  s_valid, s_data, m_ready,
      output s_ready, m_valid, m_data, m_first, m_last
   );

   modport master (
      output s_valid, s_data, m_ready,
      input  s_ready, m_valid, m_data, m_first, m_last
   );

endinterface

// File: rtl/hamming_rem_lfsr.sv
// Remainder register for systematic cyclic encoding: divides the message by
// the generator while data shifts in, then shifts the remainder out MSB-first.
module hamming_rem_lfsr
   import hamming_pkg::*;
#(
   parameter int M = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         shift_in,
   input  logic         shift_out,
   input  logic         din,
   output logic [M-1:0] rem
);

   localparam logic [3:0]   G_FULL = gen_taps(M);
   localparam logic [M-1:0] G      = G_FULL[M-1:0];

   logic [M-1:0] rem_q;
   logic [M-1:0] rem_d;
   logic         fb;

   // Next remainder: clear on codeword completion, divide step on data,
   // plain shift while the parity bits are read out.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned, which would infer a latch.
      rem_d = rem_q;
      fb    = din ^ rem_q[M-1];
      if (clear) begin
         rem_d = '0;
      end else if (shift_in) begin
         rem_d = {rem_q[M-2:0], 1'b0} ^ (fb ? G : '0);
      end else if (shift_out) begin
         rem_d = {rem_q[M-2:0], 1'b0};
      end
   end

   // Remainder state register with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      if (reset) begin
         rem_q <= '0;
      end else begin
         rem_q <= rem_d;
      end
   end

   assign rem = rem_q;

endmodule

// File: rtl/hamming_serial_encoder.sv
// Bit-serial systematic Hamming encoder: message bits pass straight through,
// followed by M parity bits and, optionally, one overall even-parity bit.
module hamming_serial_encoder
   import hamming_pkg::*;
#(
   parameter int M          = 3,
   parameter bit EXT_PARITY = 1'b0
) (
   input logic                     clk,
   input logic                     reset,
   hamming_serial_encoder_if.slave bus
);

   localparam int K      = calc_k(M);
   localparam int N      = calc_n(M);
   localparam int CW_LEN = N + int'(EXT_PARITY);
   localparam int CNT_W  = $clog2(N + 2);

   localparam logic [CNT_W-1:0] IDX_LAST_DATA = CNT_W'(K - 1);
   localparam logic [CNT_W-1:0] IDX_LAST_PAR  = CNT_W'(N - 1);
   localparam logic [CNT_W-1:0] IDX_LAST      = CNT_W'(CW_LEN - 1);
   localparam logic [M-1:0]     REM_MSB       = {1'b1, {(M-1){1'b0}}};

   generate
      if (M != 3 && M != 4) begin : g_bad_m
         $error("hamming_serial_encoder: M must be 3 or 4");
      end
   endgenerate

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             acc_q, acc_d;
   logic             m_valid_q, m_valid_d;
   logic             m_data_q, m_data_d;
   logic             m_first_q, m_first_d;
   logic             m_last_q, m_last_d;

   logic             out_free;
   logic             lfsr_clear;
   logic             lfsr_shift_in;
   logic             lfsr_shift_out;
   logic [M-1:0]     rem_w;
   logic             par_bit;

   hamming_rem_lfsr #(.M(M)) u_rem (
      .clk       (clk),
      .reset     (reset),
      .clear     (lfsr_clear),
      .shift_in  (lfsr_shift_in),
      .shift_out (lfsr_shift_out),
      .din       (bus.s_data),
      .rem       (rem_w)
   );

   // The output register may load when it is empty or being drained now.
   assign out_free = !m_valid_q || bus.m_ready;
   // Next parity bit is the remainder MSB.
   assign par_bit  = |(rem_w & REM_MSB);

   // Next-state and output-register loading; nothing moves unless free.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      acc_d          = acc_q;
      m_valid_d      = m_valid_q;
      m_data_d       = m_data_q;
      m_first_d      = m_first_q;
      m_last_d       = m_last_q;
      lfsr_clear     = 1'b0;
      lfsr_shift_in  = 1'b0;
      lfsr_shift_out = 1'b0;

      if (out_free) begin
         case (state_q)
            ST_DATA: begin
               if (bus.s_valid) begin
                  m_data_d      = bus.s_data;
                  m_valid_d     = 1'b1;
                  m_first_d     = (cnt_q == '0);
                  m_last_d      = 1'b0;
                  acc_d         = acc_q ^ bus.s_data;
                  cnt_d         = cnt_q + 1'b1;
                  lfsr_shift_in = 1'b1;
                  if (cnt_q == IDX_LAST_DATA) begin
                     state_d = ST_PARITY;
                  end
               end else begin
                  m_valid_d = 1'b0;
               end
            end

            ST_PARITY: begin
               m_data_d       = par_bit;
               m_valid_d      = 1'b1;
               m_first_d      = 1'b0;
               m_last_d       = (cnt_q == IDX_LAST);
               acc_d          = acc_q ^ par_bit;
               cnt_d          = cnt_q + 1'b1;
               lfsr_shift_out = 1'b1;
               if (cnt_q == IDX_LAST_PAR) begin
                  if (EXT_PARITY) begin
                     state_d = ST_EXT;
                  end else begin
                     state_d    = ST_DATA;
                     cnt_d      = '0;
                     acc_d      = 1'b0;
                     lfsr_clear = 1'b1;
                  end
               end
            end

            ST_EXT: begin
               m_data_d   = acc_q;
               m_valid_d  = 1'b1;
               m_first_d  = 1'b0;
               m_last_d   = 1'b1;
               state_d    = ST_DATA;
               cnt_d      = '0;
               acc_d      = 1'b0;
               lfsr_clear = 1'b1;
            end

            default: begin
               state_d = ST_DATA;
            end
         endcase
      end
   end

   // FSM, counter, accumulator and output register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_DATA;
         cnt_q     <= '0;
         acc_q     <= 1'b0;
         m_valid_q <= 1'b0;
         m_data_q  <= 1'b0;
         m_first_q <= 1'b0;
         m_last_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         m_first_q <= m_first_d;
         m_last_q  <= m_last_d;
      end
   end

   assign bus.s_ready = out_free && (state_q == ST_DATA) && !reset;
   assign bus.m_valid = m_valid_q;
   assign bus.m_data  = m_data_q;
   assign bus.m_first = m_first_q;
   assign bus.m_last  = m_last_q;

endmodule

// File: tb/tb_hamming_serial_encoder.sv
// Self-checking bench: three encoder configurations, randomized valid/ready
// traffic, reference encoding by polynomial long division.
module tb_hamming_serial_encoder;

   typedef struct {
      logic d;
      logic f;
      logic l;
   } bit_t;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] sv    = '0;
   logic [2:0] sd    = '0;
   logic [2:0] mr    = '1;
   logic [2:0] srdy, mv, md, mf, ml;

   int errors = 0;
   int checks = 0;

   // Reference model state for the unit currently under test.
   bit_t        expq[$];
   bit_t        logq[$];
   logic        src[$];
   int          cnt    = 0;
   int          pend   = 0;
   logic [10:0] msg    = '0;
   logic        exp_mv = 1'b0;

   always #5 clk = ~clk;

   hamming_serial_encoder_if if_u0 ();
   hamming_serial_encoder_if if_u1 ();
   hamming_serial_encoder_if if_u2 ();

   assign if_u0.s_valid = sv[0];
   assign if_u0.s_data  = sd[0];
   assign if_u0.m_ready = mr[0];
   assign if_u1.s_valid = sv[1];
   assign if_u1.s_data  = sd[1];
   assign if_u1.m_ready = mr[1];
   assign if_u2.s_valid = sv[2];
   assign if_u2.s_data  = sd[2];
   assign if_u2.m_ready = mr[2];

   assign srdy = {if_u2.s_ready, if_u1.s_ready, if_u0.s_ready};
   assign mv   = {if_u2.m_valid, if_u1.m_valid, if_u0.m_valid};
   assign md   = {if_u2.m_data,  if_u1.m_data,  if_u0.m_data};
   assign mf   = {if_u2.m_first, if_u1.m_first, if_u0.m_first};
   assign ml   = {if_u2.m_last,  if_u1.m_last,  if_u0.m_last};

   hamming_serial_encoder #(.M(3), .EXT_PARITY(1'b0)) u_dut0 (.clk(clk), .reset(reset), .bus(if_u0));
   hamming_serial_encoder #(.M(3), .EXT_PARITY(1'b1)) u_dut1 (.clk(clk), .reset(reset), .bus(if_u1));
   hamming_serial_encoder #(.M(4), .EXT_PARITY(1'b0)) u_dut2 (.clk(clk), .reset(reset), .bus(if_u2));

   function automatic int unit_m(input int u);
      return (u == 2) ? 4 : 3;
   endfunction

   function automatic int unit_ext(input int u);
      return (u == 1) ? 1 : 0;
   endfunction

   function automatic int unit_k(input int u);
      return (1 << unit_m(u)) - 1 - unit_m(u);
   endfunction

   function automatic int unit_len(input int u);
      return (1 << unit_m(u)) - 1 + unit_ext(u);
   endfunction

   // Systematic codeword: data * x^m + (data * x^m mod g), then optional
   // overall parity appended. Bit (len-1) is transmitted first.
   function automatic logic [15:0] encode(input int m, input int ext, input logic [10:0] data);
      logic [15:0] g, r, cw;
      int          n;
      n = (1 << m) - 1;
      g = (m == 4) ? 16'h0013 : 16'h000B;
      r = 16'(data) << m;
      for (int i = n - 1; i >= m; i--) begin
         if (r[i]) r = r ^ (g << (i - m));
      end
      cw = (16'(data) << m) | r;
      if (ext != 0) cw = (cw << 1) | 16'(^cw);
      return cw;
   endfunction

   task automatic clear_model();
      expq.delete();
      src.delete();
      cnt    = 0;
      pend   = 0;
      msg    = '0;
      exp_mv = 1'b0;
   endtask

   task automatic load_msg(input int u, input logic [10:0] data);
      for (int j = unit_k(u) - 1; j >= 0; j--) src.push_back(data[j]);
   endtask

   // One clock cycle on unit u; entered and left just after a falling edge.
   task automatic step(input int u, input int pv, input int pr);
      logic        free, srdy_exp, take;
      logic [15:0] cw;
      bit_t        e;
      sv[u] = (src.size() > 0) && ($urandom_range(99) < pv);
      if (sv[u]) sd[u] = src[0];
      else       sd[u] = 1'($urandom);
      mr[u] = ($urandom_range(99) < pr);
      #1;
      free     = !exp_mv || mr[u];
      srdy_exp = free && (pend == 0);
      checks++;
      if (srdy[u] !== srdy_exp) begin
         errors++;
         $display("FAIL s_ready unit%0d t=%0t: got %b expected %b", u, $time, srdy[u], srdy_exp);
      end
      checks++;
      if (mv[u] !== exp_mv) begin
         errors++;
         $display("FAIL m_valid unit%0d t=%0t: got %b expected %b", u, $time, mv[u], exp_mv);
      end
      if (exp_mv) begin
         if (expq.size() == 0) begin
            errors++;
            $display("FAIL model_underrun unit%0d t=%0t: got empty queue expected a pending bit", u, $time);
         end else begin
            e = expq[0];
            checks += 3;
            if (md[u] !== e.d) begin
               errors++;
               $display("FAIL m_data unit%0d t=%0t: got %b expected %b", u, $time, md[u], e.d);
            end
            if (mf[u] !== e.f) begin
               errors++;
               $display("FAIL m_first unit%0d t=%0t: got %b expected %b", u, $time, mf[u], e.f);
            end
            if (ml[u] !== e.l) begin
               errors++;
               $display("FAIL m_last unit%0d t=%0t: got %b expected %b", u, $time, ml[u], e.l);
            end
            if (mr[u]) begin
               e.d = md[u];
               e.f = mf[u];
               e.l = ml[u];
               logq.push_back(e);
               void'(expq.pop_front());
            end
         end
      end
      take = sv[u] && srdy_exp;
      if (free) begin
         if (take) begin
            e.d = sd[u];
            e.f = (cnt == 0);
            e.l = 1'b0;
            expq.push_back(e);
            void'(src.pop_front());
            msg = {msg[9:0], sd[u]};
            cnt++;
            if (cnt == unit_k(u)) begin
               cw = encode(unit_m(u), unit_ext(u), msg);
               for (int j = unit_k(u); j < unit_len(u); j++) begin
                  e.d = cw[unit_len(u) - 1 - j];
                  e.f = 1'b0;
                  e.l = (j == unit_len(u) - 1);
                  expq.push_back(e);
               end
               pend = unit_len(u) - unit_k(u);
               cnt  = 0;
               msg  = '0;
            end
            exp_mv = 1'b1;
         end else if (pend > 0) begin
            pend--;
            exp_mv = 1'b1;
         end else begin
            exp_mv = 1'b0;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   // Run unit u until all queued message bits are delivered, bounded.
   task automatic run_msgs(input int u, input int pv, input int pr, input int budget, output int cycles);
      cycles = 0;
      while (src.size() > 0 || expq.size() > 0 || pend > 0) begin
         if (cycles >= budget) begin
            errors++;
            $display("FAIL timeout unit%0d: got %0d cycles expected completion within %0d", u, cycles, budget);
            break;
         end
         step(u, pv, pr);
         cycles++;
      end
      sv[u] = 1'b0;
      mr[u] = 1'b1;
   endtask

   task automatic check_log(input string name, input int len, input logic [31:0] bits,
                            input logic [31:0] fmask, input logic [31:0] lmask);
      logic [31:0] ob, of, ol;
      ob = '0;
      of = '0;
      ol = '0;
      foreach (logq[i]) begin
         ob = {ob[30:0], logq[i].d};
         of = {of[30:0], logq[i].f};
         ol = {ol[30:0], logq[i].l};
      end
      checks += 4;
      if (logq.size() != len) begin
         errors++;
         $display("FAIL %s_len: got %0d expected %0d", name, logq.size(), len);
      end
      if (ob !== bits) begin
         errors++;
         $display("FAIL %s_bits: got %b expected %b", name, ob, bits);
      end
      if (of !== fmask) begin
         errors++;
         $display("FAIL %s_first: got %b expected %b", name, of, fmask);
      end
      if (ol !== lmask) begin
         errors++;
         $display("FAIL %s_last: got %b expected %b", name, ol, lmask);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      sv    = '0;
      mr    = '1;
      #1;
      for (int u = 0; u < 3; u++) begin
         checks++;
         if (srdy[u] !== 1'b0) begin
            errors++;
            $display("FAIL reset_s_ready unit%0d: got %b expected 0", u, srdy[u]);
         end
      end
      @(posedge clk);
      @(negedge clk);
      #1;
      for (int u = 0; u < 3; u++) begin
         checks += 5;
         if (mv[u] !== 1'b0) begin errors++; $display("FAIL reset_m_valid unit%0d: got %b expected 0", u, mv[u]); end
         if (md[u] !== 1'b0) begin errors++; $display("FAIL reset_m_data unit%0d: got %b expected 0", u, md[u]); end
         if (mf[u] !== 1'b0) begin errors++; $display("FAIL reset_m_first unit%0d: got %b expected 0", u, mf[u]); end
         if (ml[u] !== 1'b0) begin errors++; $display("FAIL reset_m_last unit%0d: got %b expected 0", u, ml[u]); end
         if (srdy[u] !== 1'b0) begin errors++; $display("FAIL reset_s_ready2 unit%0d: got %b expected 0", u, srdy[u]); end
      end
      reset = 1'b0;
      clear_model();
   endtask

   task automatic test_reset();
      do_reset();
   endtask

   task automatic check_cycles(input string name, input int got, input int exp_c);
      checks++;
      if (got != exp_c) begin
         errors++;
         $display("FAIL %s_cycles: got %0d expected %0d", name, got, exp_c);
      end
   endtask

   // Known codewords at full throughput; no bubbles beyond the parity slots.
   task automatic test_vectors();
      int cyc;
      logq.delete();
      load_msg(0, 11'b1000);
      run_msgs(0, 100, 100, 200, cyc);
      check_log("m3_vec", 7, 32'b1000101, 32'b1000000, 32'b0000001);
      check_cycles("m3_vec", cyc, 8);

      logq.delete();
      load_msg(1, 11'b1000);
      run_msgs(1, 100, 100, 200, cyc);
      check_log("m3_ext_vec", 8, 32'b10001011, 32'b10000000, 32'b00000001);
      check_cycles("m3_ext_vec", cyc, 9);

      logq.delete();
      load_msg(2, 11'b10000000000);
      load_msg(2, 11'b00000000000);
      run_msgs(2, 100, 100, 200, cyc);
      check_log("m4_vec", 30, {2'b00, 15'b100000000001001, 15'b000000000000000},
                {2'b00, 15'b100000000000000, 15'b100000000000000},
                {2'b00, 15'b000000000000001, 15'b000000000000001});
      check_cycles("m4_vec", cyc, 31);
   endtask

   // Reset after three message bits; the following word starts fresh.
   task automatic test_mid_reset();
      int cyc;
      logq.delete();
      src.push_back(1'b1);
      src.push_back(1'b0);
      src.push_back(1'b1);
      for (int i = 0; i < 3; i++) step(0, 100, 100);
      do_reset();
      logq.delete();
      load_msg(0, 11'b1101);
      run_msgs(0, 100, 100, 200, cyc);
      check_log("mid_reset", 7, 32'b1101001, 32'b1000000, 32'b0000001);
   endtask

   // Random data under random upstream gaps and downstream backpressure.
   task automatic test_backpressure();
      int          cyc;
      int          words;
      logic [10:0] data;
      for (int u = 0; u < 3; u++) begin
         words = (u == 2) ? 300 : 350;
         logq.delete();
         for (int w = 0; w < words; w++) begin
            data = 11'($urandom) & 11'((1 << unit_k(u)) - 1);
            load_msg(u, data);
         end
         run_msgs(u, 70, 60, words * unit_len(u) * 20, cyc);
         checks++;
         if (logq.size() != words * unit_len(u)) begin
            errors++;
            $display("FAIL bp_count unit%0d: got %0d bits expected %0d", u, logq.size(), words * unit_len(u));
         end
      end
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_mid_reset();
      test_backpressure();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
